// File: rtl/action_arbiter_if.sv
// ============================================================================
//  Module   : action_arbiter_if
//  Brief    : Bundle of match-engine request streams, action-engine output
//             and arbiter status for action_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface action_arbiter_if #(
    parameter int NUM_PORTS         = 4,
    parameter int DATA_WIDTH        = 512,
    parameter int ACTION_DATA_WIDTH = 128,
    parameter int CNT_WIDTH         = 16
);
    localparam int GW = $clog2(NUM_PORTS);

    logic [NUM_PORTS*DATA_WIDTH-1:0]        in_data;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0]      in_keep;
    logic [NUM_PORTS-1:0]                   in_last;
    logic [NUM_PORTS*3-1:0]                 in_action_id;
    logic [NUM_PORTS*ACTION_DATA_WIDTH-1:0] in_action_data;
    logic [NUM_PORTS-1:0]                   in_valid;
    logic [NUM_PORTS-1:0]                   in_ready;

    logic [DATA_WIDTH-1:0]                  out_data;
    logic [DATA_WIDTH/8-1:0]                out_keep;
    logic                                   out_last;
    logic [2:0]                             out_action_id;
    logic [ACTION_DATA_WIDTH-1:0]           out_action_data;
    logic                                   out_valid;
    logic                                   out_ready;

    logic [GW-1:0]                          grant_port;
    logic                                   busy;
    logic [NUM_PORTS*CNT_WIDTH-1:0]         grant_count;

    modport slave (
        input  in_data, in_keep, in_last, in_action_id, in_action_data, in_valid,
        input  out_ready,
        output in_ready,
        output out_data, out_keep, out_last, out_action_id, out_action_data, out_valid,
        output grant_port, busy, grant_count
    );

    modport master (
        output in_data, in_keep, in_last, in_action_id, in_action_data, in_valid,
        output out_ready,
        input  in_ready,
        input  out_data, out_keep, out_last, out_action_id, out_action_data, out_valid,
        input  grant_port, busy, grant_count
    );
endinterface

`default_nettype wire

// File: rtl/action_arbiter.sv
// ============================================================================
//  Module   : action_arbiter
//  Brief    : Packet-granular round-robin arbiter sharing one action engine
//             between NUM_PORTS match-engine result streams.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module action_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int DATA_WIDTH        = 512,
    parameter int ACTION_DATA_WIDTH = 128,
    parameter int CNT_WIDTH         = 16
) (
    input  wire logic            aclk,
    input  wire logic            areset,
    action_arbiter_if.slave      bus
);
    localparam int               GW    = $clog2(NUM_PORTS);
    localparam int               KW    = DATA_WIDTH / 8;
    localparam logic [GW:0]      c_num = (GW+1)'(NUM_PORTS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                      r_state_q, r_state_d;
    logic [GW-1:0]               r_grant_q, r_grant_d;
    logic [CNT_WIDTH-1:0]        r_cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]        r_cnt_d [NUM_PORTS];

    logic [DATA_WIDTH-1:0]        w_data  [NUM_PORTS];
    logic [KW-1:0]                w_keep  [NUM_PORTS];
    logic [2:0]                   w_aid   [NUM_PORTS];
    logic [ACTION_DATA_WIDTH-1:0] w_adata [NUM_PORTS];

    logic [GW-1:0]               w_win;
    logic                        w_any;
    logic [GW:0]                 w_sum;
    logic                        w_busy;
    logic [NUM_PORTS-1:0]        w_in_ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign w_data[i]  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_keep[i]  = bus.in_keep[i*KW +: KW];
        assign w_aid[i]   = bus.in_action_id[i*3 +: 3];
        assign w_adata[i] = bus.in_action_data[i*ACTION_DATA_WIDTH +: ACTION_DATA_WIDTH];
        assign bus.grant_count[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt_q[i];
    end

    // Rotating search starting one past the last grant; wrap done by subtraction
    // so non-power-of-two port counts stay correct.
    always_comb begin
        w_win = r_grant_q;
        w_any = 1'b0;
        w_sum = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_sum = {1'b0, r_grant_q} + (GW+1)'(k);
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            if (!w_any && bus.in_valid[w_sum[GW-1:0]]) begin
                w_win = w_sum[GW-1:0];
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_grant_d = r_grant_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_any) begin
                    r_state_d        = S_BUSY;
                    r_grant_d        = w_win;
                    r_cnt_d[w_win]   = r_cnt_q[w_win] + CNT_WIDTH'(1);
                end
            end
            S_BUSY: begin
                if (bus.in_valid[r_grant_q] && bus.out_ready && bus.in_last[r_grant_q]) begin
                    r_state_d = S_IDLE;
                end
            end
            default: r_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= S_IDLE;
            r_grant_q <= GW'(NUM_PORTS - 1);
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt_q[i] <= '0;
            end
        end else begin
            r_state_q <= r_state_d;
            r_grant_q <= r_grant_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    assign w_busy = (r_state_q == S_BUSY);

    always_comb begin
        w_in_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_in_ready[i] = w_busy && (r_grant_q == GW'(i)) && bus.out_ready;
        end
    end

    // Payload is always muxed from the granted port; only valid is gated by state.
    assign bus.in_ready        = w_in_ready;
    assign bus.out_data        = w_data[r_grant_q];
    assign bus.out_keep        = w_keep[r_grant_q];
    assign bus.out_last        = bus.in_last[r_grant_q];
    assign bus.out_action_id   = w_aid[r_grant_q];
    assign bus.out_action_data = w_adata[r_grant_q];
    assign bus.out_valid       = w_busy && bus.in_valid[r_grant_q];
    assign bus.grant_port      = r_grant_q;
    assign bus.busy            = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_action_arbiter.sv
// ============================================================================
//  Module   : tb_action_arbiter
//  Brief    : Scoreboard bench for action_arbiter: per-port expected-beat
//             queues plus an expected grant-order queue, checked by a monitor.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_action_arbiter;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int CW = 8;
    localparam int KW = DW / 8;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    action_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ACTION_DATA_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    action_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ACTION_DATA_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [2:0]    aid;
        logic [AW-1:0] adata;
    } beat_t;

    beat_t exp_q [NP][$];
    int    exp_grant [$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic beat_t mk_beat(int p, int b, int nb, logic [2:0] aid, logic [AW-1:0] ad);
        beat_t r;
        r.data  = {8'(p), 8'(b), 48'h5A5A_0000_1000 + 48'(b * 3 + p)};
        r.keep  = (b == nb - 1) ? 8'h0F : 8'hFF;
        r.last  = (b == nb - 1);
        r.aid   = aid;
        r.adata = ad;
        return r;
    endfunction

    task automatic drive(input int p, input beat_t bt);
        bus.in_data[p*DW +: DW]        = bt.data;
        bus.in_keep[p*KW +: KW]        = bt.keep;
        bus.in_last[p]                 = bt.last;
        bus.in_action_id[p*3 +: 3]     = bt.aid;
        bus.in_action_data[p*AW +: AW] = bt.adata;
        bus.in_valid[p]                = 1'b1;
    endtask

    // Presents one packet on port p; a 2-cycle valid gap is inserted before beat gap_beat.
    task automatic send_pkt(input int p, input int nb, input logic [2:0] aid,
                            input logic [AW-1:0] ad, input int gap_beat);
        beat_t bt;
        bit    ok;
        int    t;
        for (int b = 0; b < nb; b++) begin
            if (b == gap_beat) begin
                bus.in_valid[p] = 1'b0;
                repeat (2) @(posedge aclk);
                #1;
            end
            bt = mk_beat(p, b, nb, aid, ad);
            drive(p, bt);
            exp_q[p].push_back(bt);
            ok = 1'b0;
            t  = 0;
            while (!ok && t < 200) begin
                @(negedge aclk);
                ok = bus.in_ready[p];
                @(posedge aclk);
                #1;
                t++;
            end
            if (!ok) begin
                n_checks++;
                $display("FAIL handshake_timeout port %0d beat %0d: in_ready stayed 0, expected 1", p, b);
            end
        end
        bus.in_valid[p] = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // Monitor: handshake properties every cycle, beat/grant scoreboard on transfers.
    bit              mon_sop = 1'b1;
    int              g;
    beat_t           act_b;
    logic [NP-1:0]   exp_ir;
    always @(negedge aclk) begin
        g      = int'(bus.grant_port);
        exp_ir = '0;
        if (bus.busy) exp_ir[g] = bus.out_ready;
        chk("in_ready", bus.in_ready, exp_ir);
        chk("out_valid", bus.out_valid, bus.busy & bus.in_valid[g]);
        if (bus.out_valid && bus.out_ready) begin
            act_b = {bus.out_data, bus.out_keep, bus.out_last, bus.out_action_id, bus.out_action_data};
            if (mon_sop) begin
                if (exp_grant.size() == 0) begin
                    n_checks++;
                    $display("FAIL grant_order: unexpected packet from port %0d, expected none", g);
                end else begin
                    chk("grant_order", g, exp_grant.pop_front());
                end
                mon_sop = 1'b0;
            end
            if (exp_q[g].size() == 0) begin
                n_checks++;
                $display("FAIL beat: unexpected beat %0h from port %0d, expected none", act_b, g);
            end else begin
                chk("beat", act_b, exp_q[g].pop_front());
            end
            if (bus.out_last) mon_sop = 1'b1;
        end
        if (areset) mon_sop = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data = '0; bus.in_keep = '0; bus.in_last = '0;
        bus.in_action_id = '0; bus.in_action_data = '0; bus.in_valid = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("reset_grant_port", bus.grant_port, 3);
        chk("reset_busy", bus.busy, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_grant_count", bus.grant_count, 0);
        areset = 1'b0;

        // Single 3-beat packet on port 2
        exp_grant.push_back(2);
        fork
            send_pkt(2, 3, 3'd5, 32'hDEAD_0002, -1);
            begin
                @(posedge aclk);
                #2;
                chk("t1_busy_after_arb", bus.busy, 1);
                chk("t1_grant_port", bus.grant_port, 2);
                chk("t1_first_beat_valid", bus.out_valid, 1);
            end
        join
        chk("t1_count2", bus.grant_count[2*CW +: CW], 1);
        chk("t1_busy_done", bus.busy, 0);

        // All ports request continuously: strict rotation
        do_reset();
        for (int i = 0; i < 8; i++) exp_grant.push_back(i % NP);
        fork
            for (int i = 0; i < 16; i++) begin
                @(negedge aclk);
                chk("t2_out_valid_pattern", bus.out_valid, i % 2);
            end
        join_none
        for (int p = 0; p < NP; p++) begin
            fork
                automatic int pp = p;
                begin
                    send_pkt(pp, 1, 3'(pp), 32'hA000 + 32'(pp), -1);
                    send_pkt(pp, 1, 3'(pp + 4), 32'hB000 + 32'(pp), -1);
                end
            join_none
        end
        wait fork;
        for (int p = 0; p < NP; p++) chk("t2_count", bus.grant_count[p*CW +: CW], 2);

        // Port 1 requests mid-packet on port 0: no interleave
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        fork
            send_pkt(0, 4, 3'd2, 32'hC0C0_0000, -1);
            begin
                repeat (2) @(posedge aclk);
                #1;
                send_pkt(1, 2, 3'd3, 32'hC1C1_0001, -1);
            end
        join

        // Backpressure 1,0,0,1 and an upstream valid gap on port 3
        exp_grant.push_back(3);
        fork
            send_pkt(3, 4, 3'd6, 32'hD3D3_0003, 2);
            begin
                @(posedge aclk); #1; bus.out_ready = 1'b1;
                @(posedge aclk); #1; bus.out_ready = 1'b0;
                @(posedge aclk); #1; bus.out_ready = 1'b0;
                @(posedge aclk); #1; bus.out_ready = 1'b1;
                @(posedge aclk); #1;
                for (int i = 0; i < 2; i++) begin
                    @(negedge aclk);
                    chk("t4_gap_out_valid", bus.out_valid, 0);
                    chk("t4_gap_busy", bus.busy, 1);
                    chk("t4_gap_grant", bus.grant_port, 3);
                end
            end
        join

        // Counter wrap on port 3
        do_reset();
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            exp_grant.push_back(3);
            send_pkt(3, 1, 3'd7, 32'(i), -1);
        end
        chk("t5_count_max", bus.grant_count[3*CW +: CW], 8'hFF);
        exp_grant.push_back(3);
        send_pkt(3, 1, 3'd7, 32'hFFFF, -1);
        chk("t5_count_wrap", bus.grant_count[3*CW +: CW], 0);

        // Reset during beat 2 of a port-0 packet, then a fresh port-1 packet
        do_reset();
        exp_grant.push_back(0);
        drive(0, mk_beat(0, 0, 4, 3'd1, 32'hE0E0_0000));
        exp_q[0].push_back(mk_beat(0, 0, 4, 3'd1, 32'hE0E0_0000));
        exp_q[0].push_back(mk_beat(0, 0, 4, 3'd1, 32'hE0E0_0000));
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        bus.in_valid[0] = 1'b0;
        chk("t6_busy", bus.busy, 0);
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_grant_port", bus.grant_port, 3);
        chk("t6_counts", bus.grant_count, 0);
        exp_grant.push_back(1);
        send_pkt(1, 2, 3'd4, 32'hF1F1_0001, -1);
        chk("t6_count1", bus.grant_count[1*CW +: CW], 1);

        repeat (3) @(posedge aclk);
        #1;
        chk("end_grant_queue_empty", exp_grant.size(), 0);
        for (int p = 0; p < NP; p++) chk("end_beat_queue_empty", exp_q[p].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
